// File: rtl/instr_fetch_queue_if.sv
// Fetch front-end bundle: instruction-memory request/response, redirect from
// the jump/branch logic, and the decode-side valid/ready handshake.
interface instr_fetch_queue_if;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_instruction;
    logic [31:0] id_pc;
    logic        id_ready;

    modport master (
        output imem_req_valid, imem_req_addr, id_valid, id_instruction, id_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, id_valid, id_instruction, id_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, id_ready
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: sequential PC generation, credit-limited memory
// requests, in-order {instr, pc} queue toward decode, redirect flush/refetch.
module instr_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    instr_fetch_queue_if.master        bus
);
    localparam int unsigned PW       = $clog2(DEPTH);
    localparam int unsigned CW       = PW + 1;
    localparam logic [CW:0] LIMIT    = (CW+1)'(DEPTH);
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] START_PC = {RESET_PC[31:2], 2'b00};

    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;
    logic [31:0]   q_instr [DEPTH];
    logic [31:0]   q_pc    [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;

    logic [CW:0]   occupancy;
    logic [31:0]   redirect_base;
    logic          req_valid;
    logic          req_fire;
    logic          rsp_keep;
    logic          head_valid;
    logic          deq;

    // Credit covers both buffered words and in-flight requests (including ones
    // that will be discarded), so an accepted response always has a slot.
    always_comb begin
        occupancy     = {1'b0, count} + {1'b0, outstanding};
        redirect_base = {bus.redirect_pc[31:2], 2'b00};
        req_valid     = rst_n && !bus.redirect_valid && (occupancy < LIMIT);
        req_fire      = req_valid && bus.imem_req_ready;
        rsp_keep      = bus.imem_rsp_valid && !bus.redirect_valid && (discard == '0);
        head_valid    = (count != '0);
        deq           = head_valid && bus.id_ready && !bus.redirect_valid;
    end

    always_comb begin
        bus.imem_req_valid = req_valid;
        bus.imem_req_addr  = fetch_pc;
        bus.id_valid       = head_valid;
        bus.id_instruction = NOP;
        bus.id_pc          = '0;
        if (head_valid) begin
            bus.id_instruction = q_instr[rd_ptr];
            bus.id_pc          = q_pc[rd_ptr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= START_PC;
            rsp_pc      <= START_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
        end else if (bus.redirect_valid) begin
            // Every response still owed, minus the one dropped right now, is stale.
            fetch_pc    <= redirect_base;
            rsp_pc      <= redirect_base;
            rd_ptr      <= wr_ptr;
            count       <= '0;
            outstanding <= outstanding - CW'(bus.imem_rsp_valid);
            discard     <= outstanding - CW'(bus.imem_rsp_valid);
        end else begin
            if (req_fire)
                fetch_pc <= fetch_pc + 32'd4;
            outstanding <= outstanding + CW'(req_fire) - CW'(bus.imem_rsp_valid);
            if (bus.imem_rsp_valid && (discard != '0))
                discard <= discard - CW'(1);
            if (rsp_keep) begin
                rsp_pc <= rsp_pc + 32'd4;
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (deq)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(rsp_keep) - CW'(deq);
        end
    end

    always_ff @(posedge clk) begin
        if (rsp_keep) begin
            q_instr[wr_ptr] <= bus.imem_rsp_data;
            q_pc[wr_ptr]    <= rsp_pc;
        end
    end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed scenarios plus randomized traffic,
// checked against an event-level model of request credit and the PC stream.
module tb_instr_fetch_queue;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          live;
    } req_t;

    logic clk = 1'b0;
    logic rst_n;
    instr_fetch_queue_if bus();

    instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;
    req_t        pend[$];
    int          live_q, cyc, last_due, lat_lo, lat_hi;
    int          consumed, accepted, first_iv, redir_cyc, c0;
    logic [31:0] exp_fetch, exp_id;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a * 32'h9E37_79B9 + 32'h0000_1234;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle, entered just after a falling edge with inputs set by the caller.
    task automatic tick();
        bit          rsp_now, rsp_live, fire, deq, exp_rv;
        logic [31:0] rsp_addr;
        int          due;
        rsp_now  = 1'b0;
        rsp_live = 1'b0;
        rsp_addr = '0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            rsp_now  = 1'b1;
            rsp_live = pend[0].live;
            rsp_addr = pend[0].addr;
            pend.delete(0);
        end
        bus.imem_rsp_valid = rsp_now;
        bus.imem_rsp_data  = rsp_now ? mem_word(rsp_addr) : $urandom;
        #1;
        exp_rv = !bus.redirect_valid && ((pend.size() + int'(rsp_now) + live_q) < int'(DEPTH));
        check_eq("req_valid", 32'(bus.imem_req_valid), 32'(exp_rv));
        check_eq("id_valid", 32'(bus.id_valid), 32'(live_q > 0));
        if (bus.imem_req_valid)
            check_eq("req_addr", bus.imem_req_addr, exp_fetch);
        if (!bus.id_valid) begin
            check_eq("idle_instr", bus.id_instruction, NOP);
            check_eq("idle_pc", bus.id_pc, 32'h0);
        end
        if (bus.id_valid && first_iv == 0)
            first_iv = cyc;
        fire = bus.imem_req_valid && bus.imem_req_ready;
        deq  = bus.id_valid && bus.id_ready && !bus.redirect_valid;
        if (deq) begin
            check_eq("id_pc", bus.id_pc, exp_id);
            check_eq("id_instr", bus.id_instruction, mem_word(exp_id));
            exp_id = exp_id + 32'd4;
            live_q--;
            consumed++;
        end
        if (fire) begin
            due = cyc + int'($urandom_range(lat_hi, lat_lo));
            if (due <= last_due)
                due = last_due + 1;
            last_due = due;
            pend.push_back('{addr: bus.imem_req_addr, due: due, live: 1'b1});
            exp_fetch = exp_fetch + 32'd4;
            accepted++;
        end
        if (bus.redirect_valid) begin
            foreach (pend[i]) pend[i].live = 1'b0;
            live_q    = 0;
            exp_fetch = {bus.redirect_pc[31:2], 2'b00};
            exp_id    = exp_fetch;
            first_iv  = 0;
            redir_cyc = cyc;
        end else if (rsp_now && rsp_live) begin
            live_q++;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        bus.redirect_valid = 1'b0;
        for (int i = 0; i < n; i++)
            tick();
    endtask

    task automatic redirect(input logic [31:0] pc);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = pc;
        tick();
        bus.redirect_valid = 1'b0;
    endtask

    task automatic set_lat(input int l);
        lat_lo = l;
        lat_hi = l;
    endtask

    task automatic apply_reset();
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        rst_n = 1'b0;
        #1;
        check_eq("rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
        check_eq("rst_id_valid", 32'(bus.id_valid), 32'h0);
        check_eq("rst_id_instr", bus.id_instruction, NOP);
        check_eq("rst_id_pc", bus.id_pc, 32'h0);
        pend.delete();
        live_q    = 0;
        last_due  = 0;
        exp_fetch = RESET_PC;
        exp_id    = RESET_PC;
        consumed  = 0;
        accepted  = 0;
        first_iv  = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 1;
    endtask

    initial begin
        rst_n = 1'b0;
        cyc = 0;
        bus.imem_req_ready = 1'b1;
        bus.id_ready       = 1'b1;
        set_lat(1);

        // Free run at L=1: one instruction per cycle from cycle 3.
        apply_reset();
        run(20);
        check_eq("first_id_valid", 32'(first_iv), 32'd3);
        check_eq("freerun_count", 32'(consumed), 32'd18);

        // Backpressure: exactly DEPTH requests, then in-order drain.
        apply_reset();
        bus.id_ready = 1'b0;
        run(10);
        check_eq("bp_accepted", 32'(accepted), 32'(DEPTH));
        check_eq("bp_req_valid", 32'(bus.imem_req_valid), 32'h0);
        bus.id_ready = 1'b1;
        c0 = consumed;
        run(4);
        check_eq("bp_drain", 32'(consumed - c0), 32'd4);

        // Redirect with two requests in flight at L=3.
        apply_reset();
        set_lat(3);
        run(2);
        redirect(32'h0000_0100);
        run(12);
        check_eq("redir_latency", 32'(first_iv), 32'(redir_cyc + 5));

        // Redirect coincident with a response and a ready head; misaligned target.
        apply_reset();
        set_lat(2);
        run(6);
        redirect(32'h0000_0203);
        run(12);
        check_eq("redir2_latency", 32'(first_iv), 32'(redir_cyc + 4));

        // Address wrap past 2^32.
        set_lat(1);
        redirect(32'hFFFF_FFF8);
        c0 = consumed;
        run(10);
        check_eq("wrap_count", 32'(consumed - c0), 32'd8);

        // Asynchronous reset with three requests outstanding and a valid head.
        apply_reset();
        set_lat(4);
        bus.id_ready = 1'b0;
        run(5);
        #2;
        check_eq("pre_rst_id_valid", 32'(bus.id_valid), 32'h1);
        rst_n = 1'b0;
        #1;
        check_eq("async_req_valid", 32'(bus.imem_req_valid), 32'h0);
        check_eq("async_id_valid", 32'(bus.id_valid), 32'h0);
        check_eq("async_id_instr", bus.id_instruction, NOP);
        check_eq("async_id_pc", bus.id_pc, 32'h0);
        apply_reset();
        bus.id_ready = 1'b1;
        set_lat(1);
        run(6);
        check_eq("post_rst_count", 32'(consumed), 32'd4);

        // Randomized traffic: variable latency, stalls on both sides, redirects.
        apply_reset();
        lat_lo = 1;
        lat_hi = 5;
        for (int i = 0; i < 3000; i++) begin
            bus.imem_req_ready = ($urandom_range(9, 0) < 8);
            bus.id_ready       = ($urandom_range(9, 0) < 7);
            if ($urandom_range(99, 0) < 3)
                redirect(($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0)))
                                                     : $urandom);
            else
                run(1);
        end
        if (consumed < 500)
            check_eq("random_progress", 32'(consumed), 32'd500);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
